rect_sum_fetch: RTL and testbench
=================================

// Module: rect_sum_fetch
// PURPOSE
//  Consumer stage of the rectangle-descriptor ROM (rect1_rom, 1-cycle read latency) in the cascade classifier.
//  Per request: reads one packed rectangle descriptor, decodes it, and fetches the four corners from the
//  integral-image window buffer. Returns the rectangle pixel sum A - B - C + D to the feature evaluator over a
//  valid/ready handshake.
// PARAMETERS
//  W_DATA     20  ROM descriptor width; fields {x[19:15], y[14:10], w[9:5], h[4:0]}, unsigned
//  W_ADDR     8   ROM address width (rectangle index)
//  WIN_W      25  integral-image row pitch (24-px window plus zero column)
//  WIN_H      25  integral-image rows (24-px window plus zero row)
//  W_II_ADDR  10  integral-image buffer address width; must hold WIN_W*WIN_H-1
//  W_II_DATA  18  integral-image word width; also the width of sum_data
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          asynchronous reset, active-low
//  start_valid  in   1          request present
//  start_ready  out  1          request accepted when start_valid && start_ready
//  rect_idx     in   W_ADDR     rectangle index; sampled on acceptance
//  rom_en       out  1          ROM read enable (to en1)
//  rom_addr     out  W_ADDR     ROM address (to addr1)
//  rom_data     in   W_DATA     ROM data (from data1); valid the cycle after rom_en
//  ii_en        out  1          integral-image read enable
//  ii_addr      out  W_II_ADDR  integral-image address = row*WIN_W + col
//  ii_data      in   W_II_DATA  integral-image data; valid the cycle after ii_en
//  sum_valid    out  1          result present
//  sum_ready    in   1          result consumed when sum_valid && sum_ready
//  sum_data     out  W_II_DATA  rectangle sum, modulo 2^W_II_DATA
//  rect_err     out  1          descriptor out of window; qualified by sum_valid
//  busy         out  1          FSM not in IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state = IDLE. All outputs 0 except start_ready = 1. Accumulator and latched fields
//  cleared. An in-flight request is discarded and no result is produced for it.
//  FSM: IDLE -> ROM -> DEC -> RD0 -> RD1 -> RD2 -> RD3 -> LAST -> OUT -> IDLE.
//  Cycle numbering is relative to the acceptance cycle (cycle 0):
//  - IDLE (cycle 0): start_ready = 1. On acceptance, latch rect_idx and go to ROM.
//  - ROM (cycle 1): rom_en = 1, rom_addr = latched idx.
//  - DEC (cycle 2):
//    - Latch x, y, w, h from rom_data.
//    - Precompute r0 = y*WIN_W, r1 = (y+h)*WIN_W, c0 = x, c1 = x+w.
//    - Clear the accumulator.
//  - RD0..RD3 (cycles 3-6): ii_en = 1, one read per cycle, back to back.
//    - Address order: A = r0+c0, B = r0+c1, C = r1+c0, D = r1+c1.
//  - Accumulation: data for the read issued in cycle n arrives in cycle n+1 (cycles 4-7, LAST being cycle 7).
//    Signs are +A, -B, -C, +D. Arithmetic is unsigned modulo 2^W_II_DATA, and wrap is silent.
//  - OUT (cycle 8 onward):
//    - sum_valid = 1; sum_data and rect_err are held stable while sum_ready = 0.
//    - On the handshake go to IDLE; the next start can be accepted in the following cycle.
//  - Request-to-result latency is 8 cycles; minimum request period is 9 cycles.
//  start_ready = 1 only in IDLE; start_valid in any other state is ignored and not queued.
//  rom_en and ii_en are single-cycle pulses exactly as listed above; both are 0 in every other state.
//  ii_addr and rom_addr are 0 when their enable is 0.
//  Index beyond ROM depth: the ROM returns 0, so x = y = w = h = 0 and the four reads all target address 0.
//  The sum is 0.
// CONFIGURATION
//  Macro RECT_BOUNDS_CHK_EN.
//  - Defined: DEC checks x+w > WIN_W-1 or y+h > WIN_H-1.
//    - On violation: skip RD0..LAST (no ii_en pulses) and go straight to OUT with sum_data = 0, rect_err = 1.
//    - Latency on violation is 3 cycles.
//  - Undefined: no check is performed. rect_err is tied to 0. Addresses are truncated to W_II_ADDR.
// TESTING
//  Bench integral-image model: ii(row, col) = row*col, i.e. an all-ones image. ROM model: rect1_rom contents.
//  1. idx 0x00 (0x2d583: x=5 y=21 w=12 h=3) -> ii_addr 530, 542, 605, 617 in cycles 3-6;
//     sum_data = 36 at cycle 8; rect_err = 0.
//  2. idx 0x00 with sum_ready held 0 for 5 cycles -> sum_valid stays 1 and sum_data stays 36;
//     start_ready = 0 throughout; start_valid pulses during this time are ignored.
//  3. Back-to-back requests idx 0x00 then 0x00 -> second accepted 1 cycle after the first result handshake;
//     both sums = 36.
//  4. rst pulsed low in cycle 4 of a request -> all outputs 0 immediately; start_ready = 1;
//     no sum_valid follows.
//  5. idx 0x03 (0x7f122: y=28 out of window), macro defined -> no ii_en pulses; sum_valid in cycle 3;
//     sum_data = 0; rect_err = 1.
//  6. idx 0x90 (beyond ROM depth) -> four reads of address 0; sum_data = 0; rect_err = 0.

Source files
------------

// File: rtl/rect_sum_fetch.sv
// Rectangle-sum fetch stage: reads one descriptor from rect1_rom, fetches four integral-image corners
// and returns A - B - C + D. Optional bounds check is enabled with `define RECT_BOUNDS_CHK_EN.
module rect_sum_fetch #(
  parameter int W_DATA    = 20,
  parameter int W_ADDR    = 8,
  parameter int WIN_W     = 25,
  parameter int WIN_H     = 25,
  parameter int W_II_ADDR = 10,
  parameter int W_II_DATA = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [W_ADDR-1:0]    rect_idx,
  output logic                 rom_en,
  output logic [W_ADDR-1:0]    rom_addr,
  input  logic [W_DATA-1:0]    rom_data,
  output logic                 ii_en,
  output logic [W_II_ADDR-1:0] ii_addr,
  input  logic [W_II_DATA-1:0] ii_data,
  output logic                 sum_valid,
  input  logic                 sum_ready,
  output logic [W_II_DATA-1:0] sum_data,
  output logic                 rect_err,
  output logic                 busy
);

  // Row offsets are formed two bits wider than the buffer address so that (y+h)*WIN_W + x+w never
  // overflows before the final truncation to W_II_ADDR.
  localparam int W_RC = W_II_ADDR + 2;

  typedef enum logic [3:0] {
    IDLE, ROM, DEC, RD0, RD1, RD2, RD3, LAST, OUT
  } state_t;

  state_t               state;
  logic [W_RC-1:0]      r0, r1;
  logic [5:0]           c0, c1;
  logic [W_II_DATA-1:0] acc;

  logic [4:0]      dx, dy, dw, dh;
  logic [5:0]      xsum, ysum;
  logic [W_RC-1:0] r0_n, r1_n;

  always_comb begin
    dx   = rom_data[19:15];
    dy   = rom_data[14:10];
    dw   = rom_data[9:5];
    dh   = rom_data[4:0];
    xsum = {1'b0, dx} + {1'b0, dw};
    ysum = {1'b0, dy} + {1'b0, dh};
    r0_n = W_RC'(dy) * W_RC'(WIN_W);
    r1_n = W_RC'(ysum) * W_RC'(WIN_W);
  end

  function automatic logic [W_II_ADDR-1:0] rc(input logic [W_RC-1:0] r, input logic [5:0] c);
    logic [W_RC-1:0] full;
    full = r + W_RC'(c);
    return full[W_II_ADDR-1:0];
  endfunction

`ifdef RECT_BOUNDS_CHK_EN
  localparam logic [5:0] X_MAX = 6'(WIN_W - 1);
  localparam logic [5:0] Y_MAX = 6'(WIN_H - 1);
  logic oob;
  logic err_q;
  assign oob      = (xsum > X_MAX) || (ysum > Y_MAX);
  assign rect_err = err_q;
`else
  assign rect_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      rom_en      <= 1'b0;
      rom_addr    <= '0;
      ii_en       <= 1'b0;
      ii_addr     <= '0;
      sum_valid   <= 1'b0;
      sum_data    <= '0;
      r0          <= '0;
      r1          <= '0;
      c0          <= '0;
      c1          <= '0;
      acc         <= '0;
`ifdef RECT_BOUNDS_CHK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            state       <= ROM;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            rom_en      <= 1'b1;
            rom_addr    <= rect_idx;
          end
        end
        ROM: begin
          rom_en   <= 1'b0;
          rom_addr <= '0;
          state    <= DEC;
        end
        DEC: begin
          acc <= '0;
          r0  <= r0_n;
          r1  <= r1_n;
          c0  <= {1'b0, dx};
          c1  <= xsum;
`ifdef RECT_BOUNDS_CHK_EN
          if (oob) begin
            state     <= OUT;
            sum_valid <= 1'b1;
            sum_data  <= '0;
            err_q     <= 1'b1;
          end else begin
            state   <= RD0;
            ii_en   <= 1'b1;
            ii_addr <= rc(r0_n, {1'b0, dx});
          end
`else
          state   <= RD0;
          ii_en   <= 1'b1;
          ii_addr <= rc(r0_n, {1'b0, dx});
`endif
        end
        // Each read's data lands one state later, so the sign applied in RDn belongs to read n-1.
        RD0: begin
          ii_addr <= rc(r0, c1);
          state   <= RD1;
        end
        RD1: begin
          acc     <= acc + ii_data;
          ii_addr <= rc(r1, c0);
          state   <= RD2;
        end
        RD2: begin
          acc     <= acc - ii_data;
          ii_addr <= rc(r1, c1);
          state   <= RD3;
        end
        RD3: begin
          acc     <= acc - ii_data;
          ii_en   <= 1'b0;
          ii_addr <= '0;
          state   <= LAST;
        end
        LAST: begin
          acc       <= acc + ii_data;
          sum_data  <= acc + ii_data;
          sum_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (sum_ready) begin
            sum_valid   <= 1'b0;
            sum_data    <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
`ifdef RECT_BOUNDS_CHK_EN
            err_q       <= 1'b0;
`endif
          end
        end
        default: begin
          state       <= IDLE;
          start_ready <= 1'b1;
          busy        <= 1'b0;
          rom_en      <= 1'b0;
          rom_addr    <= '0;
          ii_en       <= 1'b0;
          ii_addr     <= '0;
          sum_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rect_sum_fetch.sv
// Directed bench for rect_sum_fetch: small ROM model and an all-ones integral image ii(row,col)=row*col.
module tb_rect_sum_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  rect_idx;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [19:0] rom_data;
  logic        ii_en;
  logic [9:0]  ii_addr;
  logic [17:0] ii_data;
  logic        sum_valid;
  logic        sum_ready;
  logic [17:0] sum_data;
  logic        rect_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  rect_sum_fetch #(
    .W_DATA(20), .W_ADDR(8), .WIN_W(25), .WIN_H(25), .W_II_ADDR(10), .W_II_DATA(18)
  ) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready), .rect_idx(rect_idx),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .ii_en(ii_en), .ii_addr(ii_addr), .ii_data(ii_data),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data),
    .rect_err(rect_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] rom_lut(input logic [7:0] a);
    case (a)
      8'h00:   return 20'h2d583;  // x=5 y=21 w=12 h=3
      8'h01:   return 20'h00318;  // x=0 y=0 w=24 h=24
      8'h02:   return 20'h08864;  // x=1 y=2 w=3 h=4
      8'h03:   return 20'h7f122;  // x=15 y=28 w=9 h=2
      default: return 20'h00000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_lut(rom_addr);
    if (ii_en) ii_data <= 18'((int'(ii_addr) / 25) * (int'(ii_addr) % 25));
    else       ii_data <= '0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the result handshake.
  task automatic run_req(input logic [7:0] idx, input int exp_lat, input logic [17:0] exp_sum,
                         input logic exp_err, input int n_rd, input int a0, input int a1,
                         input int a2, input int a3, input int hold);
    int k;
    int nrd;
    int exp_a[4];
    bit got;
    exp_a = '{a0, a1, a2, a3};
    check_eq("start_ready_idle", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    rect_idx    = idx;
    @(negedge clk);
    start_valid = 1'b0;
    k = 1;
    check_eq("rom_en", 32'(rom_en), 32'd1);
    check_eq("rom_addr", 32'(rom_addr), 32'(idx));
    check_eq("busy", 32'(busy), 32'd1);
    nrd = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      if (ii_en) begin
        if (nrd < 4) begin
          check_eq("ii_cycle", 32'(k), 32'(3 + nrd));
          check_eq("ii_addr", 32'(ii_addr), 32'(exp_a[nrd]));
        end
        nrd++;
      end
      if (sum_valid) got = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check_eq("latency", 32'(k), 32'(exp_lat));
    check_eq("n_reads", 32'(nrd), 32'(n_rd));
    check_eq("sum_data", 32'(sum_data), 32'(exp_sum));
    check_eq("rect_err", 32'(rect_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      start_valid = (h % 2 == 0);
      rect_idx    = 8'h01;
      @(negedge clk);
      check_eq("hold_valid", 32'(sum_valid), 32'd1);
      check_eq("hold_sum", 32'(sum_data), 32'(exp_sum));
      check_eq("hold_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    sum_ready   = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    check_eq("post_valid", 32'(sum_valid), 32'd0);
    check_eq("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int seen;
    rst         = 1'b0;
    start_valid = 1'b0;
    sum_ready   = 1'b0;
    rect_idx    = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_start_ready", 32'(start_ready), 32'd1);
    check_eq("rst_sum_valid", 32'(sum_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ii_en", 32'(ii_en), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_req(8'h00, 8, 18'd36, 1'b0, 4, 530, 542, 605, 617, 0);
    run_req(8'h00, 8, 18'd36, 1'b0, 4, 530, 542, 605, 617, 5);
    // back to back: next request issued right after the handshake
    run_req(8'h00, 8, 18'd36, 1'b0, 4, 530, 542, 605, 617, 0);
    run_req(8'h00, 8, 18'd36, 1'b0, 4, 530, 542, 605, 617, 0);
    run_req(8'h01, 8, 18'd576, 1'b0, 4, 0, 24, 600, 624, 0);
    run_req(8'h02, 8, 18'd12, 1'b0, 4, 51, 54, 151, 154, 0);
`ifdef RECT_BOUNDS_CHK_EN
    run_req(8'h03, 3, 18'd0, 1'b1, 0, 0, 0, 0, 0, 2);
`else
    run_req(8'h03, 8, 18'd18, 1'b0, 4, 715, 724, 765, 774, 0);
`endif
    run_req(8'h90, 8, 18'd0, 1'b0, 4, 0, 0, 0, 0, 0);

    // reset in cycle 4 of a request
    start_valid = 1'b1;
    rect_idx    = 8'h00;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_ii_en", 32'(ii_en), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("async_ii_en", 32'(ii_en), 32'd0);
    check_eq("async_ii_addr", 32'(ii_addr), 32'd0);
    check_eq("async_busy", 32'(busy), 32'd0);
    check_eq("async_start_ready", 32'(start_ready), 32'd1);
    check_eq("async_sum_valid", 32'(sum_valid), 32'd0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (sum_valid) seen++;
    end
    check_eq("no_result_after_rst", 32'(seen), 32'd0);
    check_eq("idle_after_rst", 32'(start_ready), 32'd1);
    run_req(8'h02, 8, 18'd12, 1'b0, 4, 51, 54, 151, 154, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
